// File: rtl/operand_loader_pkg.sv
// rtl/operand_loader_pkg.sv - shared state encoding and counter sizing for operand_loader
package operand_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Wide enough to hold WIDTH itself, so the bit counter can never wrap
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/operand_loader_if.sv
// rtl/operand_loader_if.sv - serial operand input and parallel operand output bundle
interface operand_loader_if #(parameter int WIDTH = 8);
    logic             ena;
    logic             start;
    logic             ser_a;
    logic             ser_b;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;

    modport master (
        output ena, start, ser_a, ser_b, out_ready,
        input  out_a, out_b, out_valid, busy, overrun
    );

    modport slave (
        input  ena, start, ser_a, ser_b, out_ready,
        output out_a, out_b, out_valid, busy, overrun
    );
endinterface

// File: rtl/operand_loader_ser_shift_reg.sv
// rtl/operand_loader_ser_shift_reg.sv - MSB-first serial-in/parallel-out register with clear and enable
module ser_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= {r_q[WIDTH-2:0], i_din};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - collects two MSB-first serial operands and presents them as a valid/ready pair
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    operand_loader_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_overrun;

    logic             w_handshake;
    logic             w_clr;
    logic             w_shift_en;
    logic             w_last_bit;
    logic [WIDTH-1:0] w_qa;
    logic [WIDTH-1:0] w_qb;

    assign w_handshake = bus.ena && (r_state == ST_HOLD) && bus.out_ready;
    assign w_clr       = bus.ena && bus.start &&
                         ((r_state == ST_IDLE) || w_handshake);
    assign w_shift_en  = bus.ena && (r_state == ST_SHIFT);
    assign w_last_bit  = (r_cnt == CW'(WIDTH - 1));

    ser_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_en  (w_shift_en),
        .i_din (bus.ser_a),
        .o_q   (w_qa)
    );

    ser_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_en  (w_shift_en),
        .i_din (bus.ser_b),
        .o_q   (w_qb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (bus.ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_SHIFT;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (bus.start) begin
                        r_overrun <= 1'b1;
                    end
                    r_cnt <= r_cnt + CW'(1);
                    // The final bit is taken straight from the serial inputs so
                    // the outputs load on the same edge as the last sample
                    if (w_last_bit) begin
                        r_state     <= ST_HOLD;
                        r_out_a     <= {w_qa[WIDTH-2:0], bus.ser_a};
                        r_out_b     <= {w_qb[WIDTH-2:0], bus.ser_b};
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (bus.start) begin
                            r_state <= ST_SHIFT;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (bus.start) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_a     = r_out_a;
    assign bus.out_b     = r_out_b;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.overrun   = r_overrun;

endmodule
